// File: rtl/comparator_serial.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, stopping at the first differing digit.
module comparator_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             LT,
    output logic             GT
);

    localparam int ND = WIDTH / DIGIT;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [KW-1:0]    K_TOP    = KW'(ND - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k_r;
    logic             busy_r;
    logic             done_r;
    logic             eq_r;
    logic             lt_r;
    logic             gt_r;

    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic             dig_eq_s;
    logic             dig_gt_s;

    // Current digit is always the top DIGIT bits of the shift registers.
    always_comb begin
        a_dig_s  = a_r[WIDTH-1 -: DIGIT];
        b_dig_s  = b_r[WIDTH-1 -: DIGIT];
        dig_eq_s = (a_dig_s == b_dig_s);
        dig_gt_s = (a_dig_s > b_dig_s);
    end

    // Control FSM, operand shift registers and registered result flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            k_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        // Flipping the sign bit maps two's complement onto
                        // offset binary, so the scan is always unsigned.
                        a_r     <= A ^ (SIGNED ? MSB_MASK : '0);
                        b_r     <= B ^ (SIGNED ? MSB_MASK : '0);
                        k_r     <= K_TOP;
                        busy_r  <= 1'b1;
                        state_r <= SCAN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (!dig_eq_s) begin
                        gt_r    <= dig_gt_s;
                        lt_r    <= ~dig_gt_s;
                        eq_r    <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (k_r == '0) begin
                        gt_r    <= 1'b0;
                        lt_r    <= 1'b0;
                        eq_r    <= 1'b1;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        k_r     <= k_r - KW'(1);
                        a_r     <= a_r << DIGIT;
                        b_r     <= b_r << DIGIT;
                        state_r <= SCAN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign EQ   = eq_r;
    assign LT   = lt_r;
    assign GT   = gt_r;

endmodule

// File: tb/tb_comparator_serial.sv
// Directed self-checking bench for comparator_serial (WIDTH=16, DIGIT=4).
module tb_comparator_serial;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        SIGNED;
    logic [15:0] A;
    logic [15:0] B;
    logic        BUSY;
    logic        DONE;
    logic        EQ;
    logic        LT;
    logic        GT;

    int total = 0;
    int bad   = 0;

    comparator_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SIGNED(SIGNED),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .EQ(EQ), .LT(LT), .GT(GT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Launch one compare and count edges from acceptance to DONE (-1 on timeout).
    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output int lat, output logic busy_ok);
        bit found;
        @(negedge CLK);
        A = a; B = b; SIGNED = s; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = -1;
        busy_ok = BUSY;
        found = 1'b0;
        for (int n = 1; n <= 40 && !found; n++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = n;
                found = 1'b1;
                if (BUSY) busy_ok = 1'b0;
            end else if (!BUSY) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b1; SIGNED = 1'b0; A = 16'h0001; B = 16'h0002;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({BUSY, DONE, EQ, LT, GT} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000", {BUSY, DONE, EQ, LT, GT});
        end
        @(negedge CLK);
        START = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++;
        if ({BUSY, DONE, EQ, LT, GT} !== 5'b00000) begin
            bad++;
            $display("FAIL start_under_reset got=%b want=00000", {BUSY, DONE, EQ, LT, GT});
        end
    endtask

    task automatic test_equal;
        int lat; logic bok;
        run_cmp(16'hBEEF, 16'hBEEF, 1'b0, lat, bok);
        total++;
        if (lat !== 4 || bok !== 1'b1) begin
            bad++;
            $display("FAIL equal_latency got lat=%0d busy_ok=%b want lat=4 busy_ok=1", lat, bok);
        end
        total++;
        if ({EQ, LT, GT} !== 3'b100) begin
            bad++;
            $display("FAIL equal_flags got=%b want=100", {EQ, LT, GT});
        end
        @(posedge CLK); #1;
        total++;
        if ({DONE, BUSY, EQ, LT, GT} !== 5'b00100) begin
            bad++;
            $display("FAIL done_drop got=%b want=00100", {DONE, BUSY, EQ, LT, GT});
        end
    endtask

    task automatic test_unsigned;
        int lat; logic bok;
        run_cmp(16'h1234, 16'h9234, 1'b0, lat, bok);
        total++;
        if (lat !== 1 || {EQ, LT, GT} !== 3'b010) begin
            bad++;
            $display("FAIL uns_top_lt got lat=%0d flags=%b want lat=1 flags=010", lat, {EQ, LT, GT});
        end
        run_cmp(16'h00A5, 16'h00A4, 1'b0, lat, bok);
        total++;
        if (lat !== 4 || {EQ, LT, GT} !== 3'b001) begin
            bad++;
            $display("FAIL uns_low_gt got lat=%0d flags=%b want lat=4 flags=001", lat, {EQ, LT, GT});
        end
    endtask

    task automatic test_signed;
        int lat; logic bok;
        run_cmp(16'h8000, 16'h0001, 1'b1, lat, bok);
        total++;
        if (lat !== 1 || {EQ, LT, GT} !== 3'b010) begin
            bad++;
            $display("FAIL sgn_8000_lt got lat=%0d flags=%b want lat=1 flags=010", lat, {EQ, LT, GT});
        end
        run_cmp(16'h8000, 16'h0001, 1'b0, lat, bok);
        total++;
        if (lat !== 1 || {EQ, LT, GT} !== 3'b001) begin
            bad++;
            $display("FAIL uns_8000_gt got lat=%0d flags=%b want lat=1 flags=001", lat, {EQ, LT, GT});
        end
        run_cmp(16'hFFFF, 16'hFFFE, 1'b1, lat, bok);
        total++;
        if (lat !== 4 || {EQ, LT, GT} !== 3'b001) begin
            bad++;
            $display("FAIL sgn_ffff_gt got lat=%0d flags=%b want lat=4 flags=001", lat, {EQ, LT, GT});
        end
    endtask

    task automatic test_latency_table;
        logic [15:0] va [6] = '{16'h1200, 16'hABCD, 16'h7FFF, 16'h0000, 16'hFFF0, 16'h1234};
        logic [15:0] vb [6] = '{16'h1300, 16'hAB0D, 16'h8000, 16'h0000, 16'h0001, 16'h1235};
        logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int          vl [6] = '{2, 3, 1, 4, 1, 4};
        logic [2:0]  vf [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010};
        int lat; logic bok;
        for (int i = 0; i < 6; i++) begin
            run_cmp(va[i], vb[i], vs[i], lat, bok);
            total++;
            if (lat !== vl[i] || {EQ, LT, GT} !== vf[i] || bok !== 1'b1) begin
                bad++;
                $display("FAIL table[%0d] got lat=%0d flags=%b busy_ok=%b want lat=%0d flags=%b busy_ok=1",
                         i, lat, {EQ, LT, GT}, bok, vl[i], vf[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] done_seq;
        @(negedge CLK);
        A = 16'h1111; B = 16'h1111; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        A = 16'h0000; B = 16'h0001; START = 1'b1;
        done_seq = '0;
        for (int n = 0; n < 4; n++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            done_seq[n] = DONE;
        end
        total++;
        if (done_seq !== 4'b1000 || {EQ, LT, GT} !== 3'b100) begin
            bad++;
            $display("FAIL ignore_start got done_seq=%b flags=%b want done_seq=1000 flags=100", done_seq, {EQ, LT, GT});
        end
        A = 16'h2000; B = 16'h1000; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        total++;
        if ({BUSY, DONE, EQ, LT, GT} !== 5'b10100) begin
            bad++;
            $display("FAIL b2b_accept got=%b want=10100", {BUSY, DONE, EQ, LT, GT});
        end
        @(posedge CLK); #1;
        total++;
        if ({BUSY, DONE, EQ, LT, GT} !== 5'b01001) begin
            bad++;
            $display("FAIL b2b_result got=%b want=01001", {BUSY, DONE, EQ, LT, GT});
        end
    endtask

    task automatic test_reset_mid_scan;
        int lat; logic bok; logic saw_done;
        @(negedge CLK);
        A = 16'h4444; B = 16'h4444; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        total++;
        if ({BUSY, DONE, EQ, LT, GT} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_abort got=%b want=00000", {BUSY, DONE, EQ, LT, GT});
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (DONE) saw_done = 1'b1;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            if (DONE) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0 || {EQ, LT, GT} !== 3'b000) begin
            bad++;
            $display("FAIL reset_no_done got done=%b flags=%b want done=0 flags=000", saw_done, {EQ, LT, GT});
        end
        run_cmp(16'h0005, 16'h0003, 1'b0, lat, bok);
        total++;
        if (lat !== 4 || {EQ, LT, GT} !== 3'b001) begin
            bad++;
            $display("FAIL after_reset got lat=%0d flags=%b want lat=4 flags=001", lat, {EQ, LT, GT});
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_unsigned();
        test_signed();
        test_latency_table();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_serial.md
# comparator_serial

Parametrised, multi-cycle magnitude comparator and successor to the fixed 8-bit combinational comparator. It scans two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops at the first digit that differs. It supports unsigned and two's-complement modes, uses a START/BUSY/DONE handshake, and holds its EQ/LT/GT flags in registers. It sits beside the ALU for wide compares where a single-cycle WIDTH-bit compare chain would break timing.

## Interface
- WIDTH, 16: operand width in bits. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 4: bits examined per cycle, 1..WIDTH. Number of digits is ND = WIDTH/DIGIT.
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request a compare; accepted only when BUSY=0.
- SIGNED  input  1  compare mode, sampled with START: 1 = two's complement, 0 = unsigned.
- A  input  WIDTH  operand A, sampled with START.
- B  input  WIDTH  operand B, sampled with START.
- BUSY  output  1  high while a compare is in progress.
- DONE  output  1  one-cycle pulse when EQ/LT/GT are updated.
- EQ  output  1  A == B for the last completed compare.
- LT  output  1  A < B for the last completed compare.
- GT  output  1  A > B for the last completed compare.

## Operation
- Reset (RST_N=0, asynchronous): FSM goes to IDLE. BUSY, DONE, EQ, LT and GT are all 0; the digit index is cleared.
- FSM states:
  - IDLE: BUSY=0.
  - SCAN: BUSY=1.
- IDLE → SCAN: on an edge with START=1.
  - Latch A and B into internal shift registers.
  - If SIGNED=1, invert bit WIDTH-1 of both latched operands (offset-binary mapping). After this, every compare is an unsigned compare.
  - Digit index k is set to ND-1.
- Each edge in SCAN compares digit k of both operands (bits k·DIGIT+DIGIT-1 .. k·DIGIT).
  - Digits differ: set GT=1 if A's digit > B's digit, otherwise LT=1. Clear the other two flags, pulse DONE, go to IDLE.
  - Digits equal and k=0: set EQ=1, clear LT and GT, pulse DONE, go to IDLE.
  - Digits equal and k>0: k ← k-1, stay in SCAN.
- Flag rules:
  - EQ, LT and GT change only at completion.
  - Between completions they hold their last value.
  - After the first completion exactly one of them is high.
  - Before the first completion all three are 0.
- START while BUSY=1 is ignored: no re-latch and no effect on the scan in progress.
- A, B and SIGNED are don't-care except on the START-accept edge.
- No arithmetic carry chain. Per-digit compare is a DIGIT-bit magnitude compare.
- DIGIT=WIDTH degenerates to a single-cycle registered compare.

## Timing
- START accepted at edge t0; BUSY=1 from t0.
- Completion occurs at edge t0+n, where n is the digits examined: 1 + (number of leading equal digits), capped at ND.
  - Best case n=1 (top digit differs).
  - Worst case n=ND (equal operands, or difference only in digit 0).
- After edge t0+n: DONE=1, BUSY=0, flags valid. DONE drops at edge t0+n+1 unless a new completion occurs on that edge.
- Back-to-back: START high during the DONE cycle is accepted at edge t0+n+1, so there are no dead cycles between compares.
- Reset mid-SCAN: abort immediately. No DONE pulse; flags cleared to 0. The next compare starts fresh after RST_N deasserts.
- START coincident with reset deassertion edge: ignored (RST_N still low at that edge).

## Test plan
- WIDTH=16, DIGIT=4, unsigned, A=0xBEEF, B=0xBEEF → BUSY for 4 cycles, DONE at t0+4, EQ=1, LT=GT=0.
- Unsigned, A=0x1234, B=0x9234 → DONE at t0+1, LT=1. Then A=0x00A5, B=0x00A4 → DONE at t0+4, GT=1.
- A=0x8000, B=0x0001: SIGNED=1 → LT=1 after 1 cycle; SIGNED=0 → GT=1 after 1 cycle. A=0xFFFF, B=0xFFFE signed → GT=1 after 4 cycles.
- Pulse START with new operands (A=0, B=1) mid-scan of an equal-operand compare → ignored; the original compare completes with EQ=1 at t0+4. Then START held during the DONE cycle → second compare accepted with no gap; flags hold until its completion.
- Assert RST_N=0 at t0+2 of a 4-digit scan → BUSY, DONE, EQ, LT, GT all 0 immediately. No DONE pulse. The next compare (A=5, B=3) gives GT=1 at its own t0+4.
- Randomised sweep over WIDTH∈{8,16,32} and DIGIT∈{1,2,4,WIDTH}, both modes → flags match a reference compare, and latency equals the leading-equal-digit count + 1.
